// File: rtl/job_sched_rr.sv
// Round-robin scheduler sharing one start/done worker among NUM_REQ requesters.
// Optional watchdog abort of stuck jobs is compiled in with JOB_SCHED_WATCHDOG_EN.
//
// state    | meaning
// ---------+----------------------------------------------------------
// IDLE     | waiting for worker_ready and any req; picks next requester
// LAUNCH   | worker_start pulse for the granted requester
// WAIT     | waiting for worker_done (watchdog counts here if enabled)
// COMPLETE | ack pulse to granted requester, advance rr pointer
// ABORT    | watchdog expired: ack + timeout_err, advance rr pointer
module job_sched_rr #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ),
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] ack,
  output logic [ID_W-1:0]    grant_id,
  output logic               busy,
  input  logic               worker_ready,
  output logic               worker_start,
  input  logic               worker_done,
  output logic               timeout_err
);

`ifdef JOB_SCHED_WATCHDOG_EN
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE, S_ABORT} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_COMPLETE} state_t;
`endif

  localparam logic [ID_W-1:0] LAST_ID = ID_W'(NUM_REQ - 1);

  state_t              state, state_nxt;
  logic [ID_W-1:0]     ptr, ptr_nxt, grant_nxt;
  logic [ID_W-1:0]     sel_id;
  logic                sel_valid;
  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]  req_rot;
  logic [ID_W:0]       sum;

  // Rotate req so bit 0 is the requester at ptr; scan downward so the
  // lowest rotated offset (closest to ptr) wins.
  always_comb begin
    req_dbl   = {req, req};
    req_rot   = NUM_REQ'(req_dbl >> ptr);
    sel_valid = 1'b0;
    sel_id    = '0;
    sum       = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) begin
        sum = {1'b0, ptr} + (ID_W+1)'(i);
        if (sum >= (ID_W+1)'(NUM_REQ)) sum = sum - (ID_W+1)'(NUM_REQ);
        sel_id    = sum[ID_W-1:0];
        sel_valid = 1'b1;
      end
    end
  end

`ifdef JOB_SCHED_WATCHDOG_EN
  logic [15:0] wd_cnt, wd_cnt_nxt;
  logic        wd_hit;
  assign wd_hit = ((wd_cnt + 16'd1) == 16'(TIMEOUT));
`endif

  always_comb begin
    state_nxt    = state;
    ptr_nxt      = ptr;
    grant_nxt    = grant_id;
    busy         = (state != S_IDLE);
    worker_start = 1'b0;
    ack          = '0;
    timeout_err  = 1'b0;
`ifdef JOB_SCHED_WATCHDOG_EN
    wd_cnt_nxt   = wd_cnt;
`endif
    case (state)
      S_IDLE: begin
        if (worker_ready && sel_valid) begin
          grant_nxt = sel_id;
          state_nxt = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        worker_start = 1'b1;
        state_nxt    = S_WAIT;
`ifdef JOB_SCHED_WATCHDOG_EN
        wd_cnt_nxt   = '0;
`endif
      end
      S_WAIT: begin
`ifdef JOB_SCHED_WATCHDOG_EN
        wd_cnt_nxt = wd_cnt + 16'd1;
        // done takes priority over a simultaneous expiry
        if (worker_done)  state_nxt = S_COMPLETE;
        else if (wd_hit)  state_nxt = S_ABORT;
`else
        if (worker_done)  state_nxt = S_COMPLETE;
`endif
      end
      S_COMPLETE: begin
        ack       = NUM_REQ'(1) << grant_id;
        ptr_nxt   = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
        state_nxt = S_IDLE;
      end
`ifdef JOB_SCHED_WATCHDOG_EN
      S_ABORT: begin
        ack         = NUM_REQ'(1) << grant_id;
        timeout_err = 1'b1;
        ptr_nxt     = (grant_id == LAST_ID) ? '0 : grant_id + ID_W'(1);
        state_nxt   = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      ptr      <= '0;
      grant_id <= '0;
`ifdef JOB_SCHED_WATCHDOG_EN
      wd_cnt   <= '0;
`endif
    end else begin
      state    <= state_nxt;
      ptr      <= ptr_nxt;
      grant_id <= grant_nxt;
`ifdef JOB_SCHED_WATCHDOG_EN
      wd_cnt   <= wd_cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_job_sched_rr.sv
// Self-checking bench for job_sched_rr: directed vector table, hand-written
// corner sequences and a randomized run against a timeline reference model.
module tb_job_sched_rr;
  localparam int NREQ = 4;
  localparam int IDW  = 2;
  localparam int TMO  = 8;
  localparam int BIG  = 1 << 30;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] ack;
  logic [IDW-1:0]  grant_id;
  logic            busy;
  logic            worker_ready = 1'b0;
  logic            worker_start;
  logic            worker_done = 1'b0;
  logic            timeout_err;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  job_sched_rr #(.NUM_REQ(NREQ), .ID_W(IDW), .TIMEOUT(TMO)) dut (
    .clk          (clk),
    .rst          (rst),
    .req          (req),
    .ack          (ack),
    .grant_id     (grant_id),
    .busy         (busy),
    .worker_ready (worker_ready),
    .worker_start (worker_start),
    .worker_done  (worker_done),
    .timeout_err  (timeout_err)
  );

  typedef struct {
    logic [3:0] r;
    logic       rd;
    logic       d;
    logic [3:0] e_ack;
    logic       e_start;
    logic       e_busy;
    logic [1:0] e_gid;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] r, input logic rd, input logic d,
                     input logic [3:0] ea, input logic es, input logic eb,
                     input logic [1:0] eg);
    vec_t v;
    v.r = r; v.rd = rd; v.d = d; v.e_ack = ea; v.e_start = es; v.e_busy = eb; v.e_gid = eg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic chk_out(input string tag, input logic [3:0] ea, input logic es,
                         input logic eb, input logic [1:0] eg, input logic eto);
    chk({tag, ".ack"},   int'(ack),          int'(ea));
    chk({tag, ".start"}, int'(worker_start), int'(es));
    chk({tag, ".busy"},  int'(busy),         int'(eb));
    chk({tag, ".gid"},   int'(grant_id),     int'(eg));
    chk({tag, ".terr"},  int'(timeout_err),  int'(eto));
  endtask

  task automatic cyc_drive(input logic [3:0] r, input logic rd, input logic d);
    @(posedge clk); #1;
    req = r; worker_ready = rd; worker_done = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req = '0; worker_ready = 1'b0; worker_done = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    int idx;
    for (int k = 0; k < NREQ; k++) begin
      idx = (p + k) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  int         order[$];
  int         start_cyc[$];
  int         ack_cnt, cnt_a, cnt_b, k_ack;
  logic       to_at_ack, prev_start;
  logic [3:0] ack_at;
  int         g_cyc, a_cyc, m_gid, m_ptr;
  bit         m_to, active, idle_now;
  logic [3:0] e_ack, ack_seen;

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    // reset state
    @(negedge clk);
    chk_out("reset", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);

    // directed vector table
    add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd2);
    add(4'b0100, 1'b1, 1'b0, 4'b0100, 1'b0, 1'b1, 2'd2);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2);
    add(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd2);
    add(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
    add(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
    add(4'b1001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
    add(4'b1001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(4'b1001, 1'b1, 1'b0, 4'b0000, 1'b1, 1'b1, 2'd3);
    add(4'b1001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd3);
    add(4'b1001, 1'b1, 1'b0, 4'b1000, 1'b0, 1'b1, 2'd3);
    add(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd3);
    add(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b1, 1'b1, 2'd0);
    add(4'b0001, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b1, 2'd0);
    add(4'b0001, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b1, 2'd0);
    add(4'b0001, 1'b1, 1'b0, 4'b0001, 1'b0, 1'b1, 2'd0);
    add(4'b0000, 1'b1, 1'b1, 4'b0000, 1'b0, 1'b0, 2'd0);
    add(4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 1'b0, 2'd0);

    do_reset();
    foreach (tbl[i]) begin
      cyc_drive(tbl[i].r, tbl[i].rd, tbl[i].d);
      chk_out($sformatf("vec%0d", i), tbl[i].e_ack, tbl[i].e_start, tbl[i].e_busy,
              tbl[i].e_gid, 1'b0);
    end

    // all requesting, done one cycle after start: strict rotation, 4-cycle jobs
    do_reset();
    prev_start = 1'b0;
    ack_cnt = 0;
    for (int c = 0; c < 20; c++) begin
      cyc_drive(4'b1111, 1'b1, prev_start);
      if (worker_start) begin
        order.push_back(int'(grant_id));
        start_cyc.push_back(c);
      end
      if (ack != 4'b0000) begin
        ack_cnt++;
        chk("rot.ack_onehot", int'(ack), int'(4'(1) << grant_id));
      end
      prev_start = worker_start;
    end
    chk("rot.num_starts", order.size(), 5);
    chk("rot.num_acks", ack_cnt, 5);
    for (int i = 0; i < 5 && i < order.size(); i++)
      chk($sformatf("rot.order%0d", i), order[i], i % NREQ);
    for (int i = 1; i < start_cyc.size(); i++)
      chk($sformatf("rot.period%0d", i), start_cyc[i] - start_cyc[i-1], 4);

    // worker not ready: request must wait
    cnt_a = 0; cnt_b = 0;
    for (int c = 0; c < 10; c++) begin
      cyc_drive(4'b0001, 1'b0, 1'b0);
      if (worker_start) cnt_a++;
      if (busy) cnt_b++;
    end
    chk("nrdy.starts", cnt_a, 0);
    chk("nrdy.busy", cnt_b, 0);
    cyc_drive(4'b0001, 1'b1, 1'b0);
    cyc_drive(4'b0001, 1'b1, 1'b0);
    chk_out("nrdy.launch", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    cyc_drive(4'b0001, 1'b1, 1'b1);
    cyc_drive(4'b0001, 1'b1, 1'b0);
    chk_out("nrdy.ack", 4'b0001, 1'b0, 1'b1, 2'd0, 1'b0);

    // serve requester 2 (ptr -> 3), then reset during requester 3's WAIT
    cyc_drive(4'b0100, 1'b1, 1'b0);
    cyc_drive(4'b0100, 1'b1, 1'b0);
    chk_out("rst.pre_launch", 4'b0000, 1'b1, 1'b1, 2'd2, 1'b0);
    cyc_drive(4'b0100, 1'b1, 1'b1);
    cyc_drive(4'b0100, 1'b1, 1'b0);
    chk_out("rst.pre_ack", 4'b0100, 1'b0, 1'b1, 2'd2, 1'b0);
    cyc_drive(4'b1000, 1'b1, 1'b0);
    cyc_drive(4'b1000, 1'b1, 1'b0);
    chk_out("rst.launch3", 4'b0000, 1'b1, 1'b1, 2'd3, 1'b0);
    cyc_drive(4'b1000, 1'b1, 1'b0);
    cyc_drive(4'b1000, 1'b1, 1'b0);
    #1 rst = 1'b1;
    #1 chk_out("rst.async", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    req = 4'b1010;
    @(negedge clk);
    chk_out("rst.held", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk_out("rst.released", 4'b0000, 1'b0, 1'b0, 2'd0, 1'b0);
    cyc_drive(4'b1010, 1'b1, 1'b0);
    chk_out("rst.reserve", 4'b0000, 1'b1, 1'b1, 2'd1, 1'b0);
    cyc_drive(4'b1010, 1'b1, 1'b1);
    cyc_drive(4'b1010, 1'b1, 1'b0);
    chk_out("rst.ack1", 4'b0010, 1'b0, 1'b1, 2'd1, 1'b0);
    cyc_drive(4'b0000, 1'b1, 1'b0);

    // stuck worker
    cyc_drive(4'b0001, 1'b1, 1'b0);
    cyc_drive(4'b0001, 1'b1, 1'b0);
    chk_out("wd.launch", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
`ifdef JOB_SCHED_WATCHDOG_EN
    k_ack = -1; to_at_ack = 1'b0; ack_at = '0;
    for (int k = 1; k <= 40 && k_ack < 0; k++) begin
      cyc_drive(4'b0001, 1'b1, 1'b0);
      if (ack != 4'b0000) begin k_ack = k; to_at_ack = timeout_err; ack_at = ack; end
      else chk("wd.early_terr", int'(timeout_err), 0);
    end
    chk("wd.abort_delay", k_ack, TMO + 1);
    chk("wd.abort_terr", int'(to_at_ack), 1);
    chk("wd.abort_ack", int'(ack_at), 1);
    cyc_drive(4'b0000, 1'b1, 1'b0);
    // done in the same cycle the count reaches TIMEOUT
    cyc_drive(4'b0001, 1'b1, 1'b0);
    cyc_drive(4'b0001, 1'b1, 1'b0);
    chk_out("wd2.launch", 4'b0000, 1'b1, 1'b1, 2'd0, 1'b0);
    k_ack = -1; to_at_ack = 1'b1;
    for (int k = 1; k <= 20 && k_ack < 0; k++) begin
      cyc_drive(4'b0001, 1'b1, (k == TMO));
      if (ack != 4'b0000) begin k_ack = k; to_at_ack = timeout_err; end
    end
    chk("wd2.done_delay", k_ack, TMO + 1);
    chk("wd2.done_wins", int'(to_at_ack), 0);
    cyc_drive(4'b0000, 1'b1, 1'b0);
`else
    cnt_a = 0; cnt_b = 0;
    for (int k = 1; k <= 40; k++) begin
      cyc_drive(4'b0001, 1'b1, 1'b0);
      if (!busy) cnt_a++;
      if (ack != 4'b0000 || timeout_err) cnt_b++;
    end
    chk("nowd.busy_low", cnt_a, 0);
    chk("nowd.ack_or_terr", cnt_b, 0);
`endif

    // randomized run against a timeline model
    do_reset();
    g_cyc = -1; a_cyc = BIG; m_gid = 0; m_ptr = 0; m_to = 1'b0;
    ack_seen = '0;
    for (int t = 0; t < 3000; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (ack_seen[i])                              req[i] = 1'b0;
        else if (!req[i] && $urandom_range(3) == 0)   req[i] = 1'b1;
        else if (req[i] && $urandom_range(31) == 0)   req[i] = 1'b0;
      end
      worker_ready = ($urandom_range(3) != 0);
      worker_done  = ($urandom_range(2) == 0);
      @(negedge clk);
      active = (g_cyc >= 0) && (t > g_cyc);
      e_ack  = (active && t == a_cyc) ? 4'(1 << m_gid) : 4'b0000;
      chk_out("rnd", e_ack, active && (t == g_cyc + 1), active, 2'(m_gid),
              active && (t == a_cyc) && m_to);
      ack_seen = ack;
      idle_now = (g_cyc < 0);
      if (active && a_cyc == BIG && t >= g_cyc + 2) begin
        if (worker_done) a_cyc = t + 1;
`ifdef JOB_SCHED_WATCHDOG_EN
        else if (t - g_cyc - 1 == TMO) begin a_cyc = t + 1; m_to = 1'b1; end
`endif
      end
      if (active && t == a_cyc) begin
        g_cyc = -1; a_cyc = BIG; m_to = 1'b0;
        m_ptr = (m_gid + 1) % NREQ;
      end
      if (idle_now && worker_ready && req != 4'b0000) begin
        m_gid = rr_pick(req, m_ptr);
        g_cyc = t;
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/job_sched_rr.md
Name: job_sched_rr

Overview:
- Round-robin scheduler that shares one start/done worker FSM among NUM_REQ requesters.
- The worker has a ready/busy interface, one-cycle `start` and one-cycle `done`.
- The scheduler picks a requester, launches the worker, waits for completion and returns a one-cycle ack to the granted requester.
- Sits between requester agents and a single worker instance; the worker is never started while not ready.

Parameters:
- NUM_REQ, 4: number of requesters, legal range 2..16.
- ID_W, $clog2(NUM_REQ): width of grant_id.
- TIMEOUT, 255: WAIT-state cycle limit. Used only when the watchdog is compiled in; legal range 1..65535.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- req  input  NUM_REQ  per-requester job request, level; held until the matching ack.
- ack  output  NUM_REQ  one-hot, one-cycle completion pulse to the granted requester.
- grant_id  output  ID_W  index of the requester currently or last served.
- busy  output  1  high whenever the state is not IDLE.
- worker_ready  input  1  worker idle and able to accept start.
- worker_start  output  1  one-cycle launch pulse to the worker.
- worker_done  input  1  one-cycle completion pulse from the worker.
- timeout_err  output  1  one-cycle pulse marking a watchdog-aborted job; tied 0 when the watchdog is compiled out.

Behaviour:
- Reset:
  - Interface: one clock, `clk`; reset `rst` is asynchronous and active-high.
  - While `rst` is high: state=IDLE; ack=0, grant_id=0, busy=0, worker_start=0, timeout_err=0; rr pointer ptr=0; watchdog counter=0.
  - Reset mid-job drops the job silently with no ack. The worker is not told; the scheduler simply waits for worker_ready in IDLE.
- States: IDLE, LAUNCH, WAIT, COMPLETE, plus ABORT when the watchdog is compiled in.
- Outputs are Moore outputs decoded from the registered state. grant_id is a register.
- IDLE:
  - If worker_ready=1 and req!=0, select the first set bit scanning ptr, ptr+1, … with wrap modulo NUM_REQ.
  - Register the selected index into grant_id, then go to LAUNCH.
  - Otherwise stay in IDLE.
- LAUNCH: worker_start=1 for exactly this cycle, then unconditionally go to WAIT.
- WAIT:
  - On worker_done=1, go to COMPLETE.
  - worker_done is ignored in every other state.
- COMPLETE:
  - ack[grant_id]=1 for this cycle only.
  - ptr <= (grant_id+1) mod NUM_REQ.
  - Go to IDLE.
- Latency:
  - req seen in IDLE at cycle 0 gives worker_start at cycle 1.
  - worker_done sampled at cycle k gives ack at cycle k+1 and IDLE at k+2.
  - Minimum job period is 4 cycles.
- A req dropped before grant is not considered. A req dropped after grant does not abort the job; ack still pulses.
- grant_id is held from selection until the next selection. It holds its last value while in IDLE.
- Fairness: a continuously requesting agent waits at most NUM_REQ-1 jobs.
- A single requester may be served back-to-back if no other req is set.
- At most one ack bit is set in any cycle. worker_start never coincides with ack.

Optional Feature:
- Macro: JOB_SCHED_WATCHDOG_EN.
- Defined:
  - A cycle counter clears on entry to WAIT and increments each WAIT cycle.
  - If it reaches TIMEOUT with no worker_done, go to ABORT.
  - ABORT: ack[grant_id]=1 and timeout_err=1 for one cycle; ptr advances as in COMPLETE; go to IDLE.
  - If worker_done arrives in the same cycle the counter reaches TIMEOUT, done wins and the FSM goes to COMPLETE.
- Undefined: no counter and no ABORT state; WAIT waits indefinitely; timeout_err is constant 0.

Test Plan:
- Reset then req=4'b0100, worker_ready=1; worker pulses done 3 cycles after start -> grant_id=2; worker_start at cycle 1; ack=4'b0100 one cycle after done; busy low again 2 cycles after done.
- req=4'b1111 held, each job done 1 cycle after start -> grant order 0,1,2,3,0; exactly one ack per 4-cycle job.
- req=4'b1001 with ptr=1 after a served job 0 -> next grant 3, then 0.
- worker_ready=0 with req=4'b0001 for 10 cycles -> no worker_start, busy=0; worker_ready rises -> start next cycle.
- rst pulsed during WAIT -> all outputs 0 next edge, no ack; after release, pending req is re-served from ptr=0.
- Watchdog macro defined, TIMEOUT=8, worker never signals done -> ack and timeout_err pulse together after 8 WAIT cycles; macro undefined -> busy stays 1 indefinitely.
